// File: rtl/packet_merge.sv
// rtl/packet_merge.sv - two-input AXI-Stream packet merger with packet-granular round-robin
// Each input lands in a small fall-through FIFO; the FSM picks one FIFO per packet.

module packet_merge_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (rd_en) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (DEPTH_BITS+1)'(1);
        2'b01:   count <= count - (DEPTH_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Nearly full leaves one slot spare, so ready can be a plain decode of count.
  assign rd_data     = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= (DEPTH_BITS+1)'(DEPTH - 1));
endmodule

module packet_merge #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                                axi_aclk,
  input  logic                                axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
  input  logic                                s_axis_tvalid_0,
  output logic                                s_axis_tready_0,
  input  logic                                s_axis_tlast_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
  input  logic                                s_axis_tvalid_1,
  output logic                                s_axis_tready_1,
  input  logic                                s_axis_tlast_1,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [31:0]                         pkt_cnt_0,
  output logic [31:0]                         pkt_cnt_1
);
  localparam int W = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH/8 + C_M_AXIS_TUSER_WIDTH + 1;

  typedef enum logic {ARB, XFER} state_t;

  state_t      state;
  logic        last_grant;
  logic        cur_sel;
  logic [31:0] cnt_0;
  logic [31:0] cnt_1;

  logic [1:0]   fifo_empty;
  logic [1:0]   fifo_nf;
  logic [W-1:0] head_0;
  logic [W-1:0] head_1;
  logic         wr_en_0;
  logic         wr_en_1;
  logic         pop;
  logic         pref;

  assign s_axis_tready_0 = !fifo_nf[0];
  assign s_axis_tready_1 = !fifo_nf[1];
  assign wr_en_0 = s_axis_tvalid_0 && s_axis_tready_0;
  assign wr_en_1 = s_axis_tvalid_1 && s_axis_tready_1;

  packet_merge_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo_0 (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .wr_en       (wr_en_0),
    .wr_data     ({s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0}),
    .rd_en       (pop && !cur_sel),
    .rd_data     (head_0),
    .empty       (fifo_empty[0]),
    .nearly_full (fifo_nf[0])
  );

  packet_merge_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo_1 (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .wr_en       (wr_en_1),
    .wr_data     ({s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1}),
    .rd_en       (pop && cur_sel),
    .rd_data     (head_1),
    .empty       (fifo_empty[1]),
    .nearly_full (fifo_nf[1])
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = cur_sel ? head_1 : head_0;
  assign m_axis_tvalid = (state == XFER) && !fifo_empty[cur_sel];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign pref          = ~last_grant;
  assign pkt_cnt_0     = cnt_0;
  assign pkt_cnt_1     = cnt_1;

  // cur_sel only changes in ARB, so a packet is never interleaved even if its FIFO underruns.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= ARB;
      last_grant <= 1'b1;
      cur_sel    <= 1'b0;
      cnt_0      <= '0;
      cnt_1      <= '0;
    end else begin
      case (state)
        ARB: begin
          if (!fifo_empty[pref]) begin
            cur_sel <= pref;
            state   <= XFER;
          end else if (!fifo_empty[last_grant]) begin
            cur_sel <= last_grant;
            state   <= XFER;
          end
        end
        XFER: begin
          if (pop && m_axis_tlast) begin
            last_grant <= cur_sel;
            state      <= ARB;
            if (cur_sel) cnt_1 <= cnt_1 + 32'd1;
            else         cnt_0 <= cnt_0 + 32'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule
